fp32_div_seq: RTL and testbench
===============================

FP32_DIV_SEQ -- requirements
Module: fp32_div_seq

Interface
REQ-001 Parameters: none; all widths are fixed by IEEE-754 single precision.
REQ-002 clk  input  1  sole clock, rising-edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair valid.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  32  dividend, fp32.
REQ-007 b  input  32  divisor, fp32.
REQ-008 out_valid  output  1  result valid.
REQ-009 out_ready  input  1  consumer accepts result.
REQ-010 q  output  32  quotient a/b, fp32.
REQ-011 flags  output  4  {invalid, div_by_zero, overflow, underflow}.

Function
REQ-012 The FSM SHALL have four states: IDLE, DIV, NORM, DONE.
REQ-013 in_ready SHALL be high only in IDLE.
REQ-014 An operand pair SHALL be accepted on an edge where in_valid and in_ready are both high.
REQ-015 On acceptance, normal operands SHALL go to DIV and special-case operands SHALL go directly to DONE.
REQ-016 DIV SHALL run 26 cycles of restoring division on the 24-bit significands (hidden bit included), giving 26 quotient bits; sticky = (final remainder != 0).
REQ-017 NORM SHALL take 1 cycle, so out_valid rises exactly 28 edges after the accepting edge for normal operands and 1 edge after it for special cases.
REQ-018 Exponent arithmetic SHALL be 10-bit signed: e = ea - eb + 127.
REQ-019 If the quotient MSB is 0, NORM SHALL shift the quotient left 1 and decrement e.
REQ-020 Any rounding carry-out SHALL renormalise the quotient and increment e.
REQ-021 Result sign SHALL be sa XOR sb for all zero, infinite and finite results; NaN sign SHALL be 0.
REQ-022 Denormal inputs SHALL be treated as signed zero (flush-to-zero).
REQ-023 Special cases:
- NaN in, 0/0 or inf/inf: q = 0x7FC00000, invalid = 1.
- finite nonzero / 0: q = inf, div_by_zero = 1.
- inf / finite: q = inf.
- finite / inf, or 0 / nonzero: q = 0.
REQ-024 Final e >= 255 SHALL set overflow = 1; the saturated value is defined in Configuration.
REQ-025 Final e <= 0 SHALL give q = signed zero with underflow = 1.
REQ-026 In DONE, q and flags SHALL stay stable while out_ready is low.
REQ-027 An edge with out_valid and out_ready both high SHALL return the FSM to IDLE.
REQ-028 There is no same-cycle re-accept: in_ready rises the cycle after the handshake.
REQ-029 in_valid presented outside IDLE SHALL be ignored, and the a/b inputs SHALL be ignored after acceptance.

Reset
REQ-030 While rst is high at an edge, the FSM SHALL go to IDLE and out_valid, q, flags and the internal datapath SHALL clear to 0.
REQ-031 in_ready SHALL be 0 while rst is high and SHALL be 1 in the first cycle after rst deasserts.
REQ-032 Reset asserted in DIV, NORM or DONE SHALL abort the operation with no result emitted.

Configuration
REQ-033 The macro FP32_DIV_RNE_EN SHALL select the rounding mode.
REQ-034 With FP32_DIV_RNE_EN defined: round-to-nearest-even using guard bit, round bit and sticky; overflow gives signed inf.
REQ-035 Without FP32_DIV_RNE_EN: truncation (round-toward-zero); overflow gives signed 0x7F7FFFFF magnitude; guard/round/sticky logic is compiled out.

Structure
REQ-036 Shared package fp32_pkg SHALL hold:
- constants BIAS = 127, EXP_MAX = 255, QNAN = 0x7FC00000, INF_MAG = 0x7F800000, MAXF_MAG = 0x7F7FFFFF;
- the FSM state typedef;
- the flags bit indices.
REQ-037 Sub-module exp_sub_bias SHALL compute the 10-bit signed ea - eb + 127; it is the divide-side counterpart of the multiplier's biased-exponent adder.
REQ-038 The significand divider step and the FSM SHALL stay in fp32_div_seq.

Verification
REQ-039 The bench SHALL cover these directed scenarios:
- Basic: a = 0x40C00000, b = 0x40000000 -> q = 0x40400000, flags = 0, out_valid exactly 28 edges after accept.
- Rounding: a = 0x3F800000, b = 0x40400000 -> q = 0x3EAAAAAB with RNE, 0x3EAAAAAA without.
- Specials: 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero; 0x00000000 / 0x00000000 -> 0x7FC00000, invalid; each with out_valid 1 edge after accept.
- Range: 0x7F7FFFFF / 0x3F000000 -> overflow, q = 0x7F800000 (RNE) or 0x7F7FFFFF (trunc); 0x00800000 / 0x40000000 -> q = 0x00000000, underflow.
- Backpressure: out_ready low 5 cycles in DONE -> q and flags stable, in_ready = 0; after the handshake, in_ready = 1 the next cycle; back-to-back operations are correct.
- Reset: rst pulsed at DIV cycle 10 -> out_valid never rises for that operation, in_ready = 1 after release, next operation correct.

Source files
------------

// File: rtl/fp32_pkg.sv
// Shared fp32 constants, FSM state type and flag bit positions for the
// sequential divider.
package fp32_pkg;

  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;

  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] INF_MAG  = 32'h7F80_0000;
  localparam logic [31:0] MAXF_MAG = 32'h7F7F_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    NORM = 2'd2,
    DONE = 2'd3
  } state_t;

  // flags = {invalid, div_by_zero, overflow, underflow}
  localparam int FLAG_INVALID = 3;
  localparam int FLAG_DZ      = 2;
  localparam int FLAG_OF      = 1;
  localparam int FLAG_UF      = 0;

endpackage

// File: rtl/fp32_div_seq_exp_sub_bias.sv
// Biased quotient exponent ea - eb + 127 in 10-bit signed form, wide enough
// to expose both overflow (>= 255) and underflow (<= 0) before packing.
module exp_sub_bias
  import fp32_pkg::*;
(
  input  logic [7:0]        ea,
  input  logic [7:0]        eb,
  output logic signed [9:0] e
);

  localparam logic signed [9:0] BIAS_S = 10'(BIAS);

  assign e = $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS_S;

endmodule

// File: rtl/fp32_div_seq.sv
// Sequential IEEE-754 single-precision divider: 26-step restoring significand
// division, one normalise/round cycle. Define FP32_DIV_RNE_EN for
// round-to-nearest-even; otherwise results are truncated.
module fp32_div_seq
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] q,
  output logic [3:0]  flags
);

  localparam logic signed [9:0] E_MAX_S = 10'(EXP_MAX);

`ifdef FP32_DIV_RNE_EN
  localparam logic [31:0] OVF_MAG = INF_MAG;
`else
  localparam logic [31:0] OVF_MAG = MAXF_MAG;
`endif

  state_t state;

  logic              sign_p0;
  logic signed [9:0] exp_p0;
  logic [25:0]       rem_p0;
  logic [23:0]       div_p0;
  logic [25:0]       quo_p0;
  logic [4:0]        cnt_p0;

  logic              sa, sb;
  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic signed [9:0] e_diff;

  assign sa = a[31];
  assign ea = a[30:23];
  assign fa = a[22:0];
  assign sb = b[31];
  assign eb = b[30:23];
  assign fb = b[22:0];

  exp_sub_bias u_exp_sub_bias (
    .ea (ea),
    .eb (eb),
    .e  (e_diff)
  );

  assign in_ready = (state == IDLE) && !rst;

  // Denormals flush to zero, so a zero exponent alone marks a zero operand.
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, s_ab;
  assign a_nan  = (ea == 8'hFF) && (fa != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (fb != 23'd0);
  assign a_inf  = (ea == 8'hFF) && (fa == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (fb == 23'd0);
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign s_ab   = sa ^ sb;

  logic        spec_hit;
  logic [31:0] spec_q;
  logic [3:0]  spec_fl;

  always_comb begin
    spec_hit = 1'b1;
    spec_q   = QNAN;
    spec_fl  = 4'd0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_q                = QNAN;
      spec_fl[FLAG_INVALID] = 1'b1;
    end else if (b_zero) begin
      spec_q           = {s_ab, INF_MAG[30:0]};
      spec_fl[FLAG_DZ] = 1'b1;
    end else if (a_inf) begin
      spec_q = {s_ab, INF_MAG[30:0]};
    end else if (b_inf || a_zero) begin
      spec_q = {s_ab, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Restoring step: one quotient bit per cycle, MSB (integer bit) first.
  logic        rem_ge;
  logic [25:0] rem_diff;
  logic [25:0] rem_next;

  always_comb begin
    rem_ge   = rem_p0 >= {2'b00, div_p0};
    rem_diff = rem_ge ? (rem_p0 - {2'b00, div_p0}) : rem_p0;
    rem_next = {rem_diff[24:0], 1'b0};
  end

`ifdef FP32_DIV_RNE_EN
  function automatic logic rne_inc(input logic lsb, input logic g,
                                   input logic r, input logic s);
    return g && (r || s || lsb);
  endfunction
`endif

  // Packs the final result and flags, saturating out-of-range exponents.
  function automatic logic [35:0] pack_sat(input logic sgn,
                                           input logic signed [9:0] e,
                                           input logic [22:0] frac);
    logic [31:0] r;
    logic [3:0]  f;
    f = 4'd0;
    if (e >= E_MAX_S) begin
      r          = {sgn, OVF_MAG[30:0]};
      f[FLAG_OF] = 1'b1;
    end else if (e <= 10'sd0) begin
      r          = {sgn, 31'd0};
      f[FLAG_UF] = 1'b1;
    end else begin
      r = {sgn, e[7:0], frac};
    end
    return {r, f};
  endfunction

  logic [23:0]       mant_n, mant_r;
  logic signed [9:0] exp_n, exp_r;
  logic [35:0]       norm_res;
  logic              unused_bits;

  always_comb begin
    mant_n = quo_p0[25] ? quo_p0[25:2] : quo_p0[24:1];
    exp_n  = quo_p0[25] ? exp_p0 : (exp_p0 - 10'sd1);
  end

`ifdef FP32_DIV_RNE_EN
  logic        guard_n, round_n, sticky_n, inc_n;
  logic [24:0] sum_n;

  always_comb begin
    guard_n  = quo_p0[25] ? quo_p0[1] : quo_p0[0];
    round_n  = quo_p0[25] ? quo_p0[0] : 1'b0;
    sticky_n = |rem_p0;
    inc_n    = rne_inc(mant_n[0], guard_n, round_n, sticky_n);
    sum_n    = {1'b0, mant_n} + {24'd0, inc_n};
    if (sum_n[24]) begin
      mant_r = sum_n[24:1];
      exp_r  = exp_n + 10'sd1;
    end else begin
      mant_r = sum_n[23:0];
      exp_r  = exp_n;
    end
  end

  assign unused_bits = mant_r[23];
`else
  assign mant_r      = mant_n;
  assign exp_r       = exp_n;
  assign unused_bits = mant_r[23] ^ quo_p0[0];
`endif

  assign norm_res = pack_sat(sign_p0, exp_r, mant_r[22:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      q         <= 32'd0;
      flags     <= 4'd0;
      sign_p0   <= 1'b0;
      exp_p0    <= 10'sd0;
      rem_p0    <= 26'd0;
      div_p0    <= 24'd0;
      quo_p0    <= 26'd0;
      cnt_p0    <= 5'd0;
    end else begin
      case (state)
        // IDLE -> DIV/DONE: capture operands or resolve specials at once
        IDLE: begin
          if (in_valid) begin
            if (spec_hit) begin
              q         <= spec_q;
              flags     <= spec_fl;
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              sign_p0 <= s_ab;
              exp_p0  <= e_diff;
              rem_p0  <= {3'b001, fa};
              div_p0  <= {1'b1, fb};
              quo_p0  <= 26'd0;
              cnt_p0  <= 5'd0;
              state   <= DIV;
            end
          end
        end
        // DIV -> NORM after 26 quotient bits
        DIV: begin
          rem_p0 <= rem_next;
          quo_p0 <= {quo_p0[24:0], rem_ge};
          cnt_p0 <= cnt_p0 + 5'd1;
          if (cnt_p0 == 5'd25) state <= NORM;
        end
        // NORM -> DONE: normalise, round, saturate
        NORM: begin
          q         <= norm_res[35:4];
          flags     <= norm_res[3:0];
          out_valid <= 1'b1;
          state     <= DONE;
        end
        // DONE -> IDLE on output handshake
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_div_seq.sv
// Directed scoreboard bench for fp32_div_seq; honours FP32_DIV_RNE_EN for the
// rounding- and overflow-dependent expectations.
module tb_fp32_div_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic [3:0]  flags;

  fp32_div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

`ifdef FP32_DIV_RNE_EN
  localparam logic [31:0] Q_THIRD = 32'h3EAA_AAAB;
  localparam logic [31:0] Q_OVF   = 32'h7F80_0000;
`else
  localparam logic [31:0] Q_THIRD = 32'h3EAA_AAAA;
  localparam logic [31:0] Q_OVF   = 32'h7F7F_FFFF;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Starts and ends just after a falling edge.
  task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                        input logic [31:0] eq, input logic [3:0] ef, input int elat,
                        input int hold);
    exp_t        e;
    int          lat;
    logic        got;
    logic [31:0] snap_q;
    logic [3:0]  snap_f;
    check({tag, "/in_ready_before"}, {31'd0, in_ready}, 32'd1);
    a         = ta;
    b         = tbv;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    e.q = eq; e.fl = ef; e.lat = elat;
    sb.push_back(e);
    @(posedge clk);
    lat = 0;
    got = 1'b0;
    while (lat < 60 && !got) begin
      @(negedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
        if (!out_valid)
          check({tag, "/in_ready_busy"}, {31'd0, in_ready}, 32'd0);
      end
      if (out_valid) got = 1'b1;
    end
    check({tag, "/out_valid_seen"}, {31'd0, got}, 32'd1);
    e = sb.pop_front();
    check({tag, "/q"}, q, e.q);
    check({tag, "/flags"}, {28'd0, flags}, {28'd0, e.fl});
    check({tag, "/latency"}, lat, e.lat);
    if (hold > 0) begin
      snap_q = q;
      snap_f = flags;
      repeat (hold) begin
        @(negedge clk);
        #1;
        check({tag, "/hold_q"}, q, snap_q);
        check({tag, "/hold_flags"}, {28'd0, flags}, {28'd0, snap_f});
        check({tag, "/hold_in_ready"}, {31'd0, in_ready}, 32'd0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    check({tag, "/in_ready_after"}, {31'd0, in_ready}, 32'd1);
    check({tag, "/out_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int   seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 32'd0;
    b         = 32'd0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset/in_ready", {31'd0, in_ready}, 32'd0);
    check("reset/out_valid", {31'd0, out_valid}, 32'd0);
    check("reset/q", q, 32'd0);
    check("reset/flags", {28'd0, flags}, 32'd0);
    rst = 1'b0;
    #1;
    check("reset/in_ready_release", {31'd0, in_ready}, 32'd1);

    run_op("basic",     32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 28, 0);
    run_op("round",     32'h3F80_0000, 32'h4040_0000, Q_THIRD,       4'b0000, 28, 0);
    run_op("div0",      32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 4'b0100, 1,  0);
    run_op("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 1,  0);
    run_op("overflow",  32'h7F7F_FFFF, 32'h3F00_0000, Q_OVF,         4'b0010, 28, 0);
    run_op("underflow", 32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 4'b0001, 28, 0);
    run_op("backpress", 32'hC0C0_0000, 32'h4000_0000, 32'hC040_0000, 4'b0000, 28, 5);
    run_op("b2b_one",   32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 4'b0000, 28, 0);
    run_op("b2b_3p5",   32'h40E0_0000, 32'h4000_0000, 32'h4060_0000, 4'b0000, 28, 0);
    run_op("nan_in",    32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 4'b1000, 1,  0);
    run_op("inf_inf",   32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 4'b1000, 1,  0);
    run_op("ninf_fin",  32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 1,  0);
    run_op("fin_ninf",  32'h3F80_0000, 32'hFF80_0000, 32'h8000_0000, 4'b0000, 1,  0);
    run_op("denorm_a",  32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 4'b0000, 1,  0);
    run_op("nzero_a",   32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 4'b0000, 1,  0);

    // Abort an operation mid-division with a reset pulse.
    a        = 32'h40C0_0000;
    b        = 32'h4000_0000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort/in_ready_in_rst", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort/in_ready_release", {31'd0, in_ready}, 32'd1);
    check("abort/out_valid_release", {31'd0, out_valid}, 32'd0);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    #1;
    check("abort/no_result", seen, 0);
    check("abort/in_ready_idle", {31'd0, in_ready}, 32'd1);

    run_op("post_abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 4'b0000, 28, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
